// File: rtl/sabr_pkg.sv
// Shared types, default widths and the saturation helper for the SABR step accumulator.
package sabr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sabr_acc_state_t;

  localparam int SABR_PROD_W = 90;
  localparam int SABR_SHIFT  = 48;
  localparam int SABR_ACC_W  = 64;
  // Working width of sabr_sat; every caller sign-extends into this before clamping.
  localparam int SABR_SAT_W  = 128;

  function automatic logic signed [SABR_SAT_W-1:0] sabr_sat(
    input logic signed [SABR_SAT_W-1:0] value,
    input int unsigned                  width
  );
    logic signed [SABR_SAT_W-1:0] max_v;
    logic signed [SABR_SAT_W-1:0] min_v;
    max_v = (128'sd1 <<< (width - 1)) - 128'sd1;
    min_v = ~max_v;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sabr_step_accum_round.sv
// Stage 1: round-half-up rescale of a raw product into the path-state format.
// Saturating behaviour is selected by SABR_STEP_ACC_SAT_EN (wraps when undefined).
module sabr_round_shift
  import sabr_pkg::*;
#(
  parameter int PROD_W = SABR_PROD_W,
  parameter int SHIFT  = SABR_SHIFT,
  parameter int ACC_W  = SABR_ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_vld,
  input  logic [PROD_W-1:0]       prod,
  output logic signed [ACC_W-1:0] r,
  output logic                    r_vld,
  output logic                    r_sat
);

  logic signed [PROD_W:0]   ext_s;
  logic signed [PROD_W:0]   half_s;
  logic signed [PROD_W:0]   sum_s;
  logic signed [PROD_W:0]   shr_s;
  logic signed [ACC_W-1:0]  r_nxt_s;
  logic                     sat_nxt_s;
`ifdef SABR_STEP_ACC_SAT_EN
  logic signed [SABR_SAT_W-1:0] wide_s;
  logic signed [SABR_SAT_W-1:0] clamp_s;
`endif
  logic signed [ACC_W-1:0]  r_r;
  logic                     r_vld_r;
  logic                     r_sat_r;

  // Round, arithmetic shift and narrow to the accumulator width.
  always_comb begin
    ext_s          = {prod[PROD_W-1], prod};
    half_s         = '0;
    half_s[SHIFT-1] = 1'b1;
    sum_s          = ext_s + half_s;
    shr_s          = sum_s >>> SHIFT;
`ifdef SABR_STEP_ACC_SAT_EN
    wide_s    = {{(SABR_SAT_W-PROD_W-1){shr_s[PROD_W]}}, shr_s};
    clamp_s   = sabr_sat(wide_s, ACC_W);
    r_nxt_s   = ACC_W'(clamp_s);
    sat_nxt_s = (clamp_s != wide_s);
`else
    r_nxt_s   = ACC_W'(shr_s);
    sat_nxt_s = 1'b0;
`endif
  end

  // Stage-1 pipeline register with its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r     <= '0;
      r_vld_r <= 1'b0;
      r_sat_r <= 1'b0;
    end else if (ce) begin
      r_vld_r <= in_vld;
      if (in_vld) begin
        r_r     <= r_nxt_s;
        r_sat_r <= sat_nxt_s;
      end else begin
        r_sat_r <= 1'b0;
      end
    end
  end

  assign r     = r_r;
  assign r_vld = r_vld_r;
  assign r_sat = r_sat_r;

endmodule

// File: rtl/sabr_step_accum.sv
// Accumulates n_steps rescaled SABR products onto a start value per Monte Carlo path.
// Optional saturation: define SABR_STEP_ACC_SAT_EN (default build wraps, sat_flag stays 0).
module sabr_step_accum
  import sabr_pkg::*;
#(
  parameter int PROD_W = SABR_PROD_W,
  parameter int SHIFT  = SABR_SHIFT,
  parameter int ACC_W  = SABR_ACC_W,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic [STEP_W-1:0] n_steps,
  input  logic [ACC_W-1:0]  init_val,
  input  logic              prod_vld,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic              sat_flag,
  output logic              ovr_flag
);

  sabr_acc_state_t         state_r;
  sabr_acc_state_t         state_s;
  logic [STEP_W-1:0]       cnt_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    sat_r;
  logic                    ovr_r;
  logic                    out_vld_r;
  logic                    busy_r;
  logic                    accept_s;
  logic signed [ACC_W-1:0] s1_s;
  logic                    s1_vld_s;
  logic                    s1_sat_s;
  logic signed [ACC_W:0]   sum2_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic                    sat2_s;
`ifdef SABR_STEP_ACC_SAT_EN
  logic signed [SABR_SAT_W-1:0] wide2_s;
  logic signed [SABR_SAT_W-1:0] clamp2_s;
`endif

  assign accept_s = (state_r == ST_ACCUM) && prod_vld;

  sabr_round_shift #(
    .PROD_W (PROD_W),
    .SHIFT  (SHIFT),
    .ACC_W  (ACC_W)
  ) u_round (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .in_vld (accept_s),
    .prod   (prod),
    .r      (s1_s),
    .r_vld  (s1_vld_s),
    .r_sat  (s1_sat_s)
  );

  // Next-state logic for the path FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = (n_steps == '0) ? ST_FLUSH : ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (prod_vld && (cnt_r == STEP_W'(1))) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_FLUSH: state_s = ST_DONE;
      ST_DONE: begin
        if (out_rdy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Stage-2 adder, widened by one bit so overflow is visible before narrowing.
  always_comb begin
    sum2_s = {acc_r[ACC_W-1], acc_r} + {s1_s[ACC_W-1], s1_s};
`ifdef SABR_STEP_ACC_SAT_EN
    wide2_s   = {{(SABR_SAT_W-ACC_W-1){sum2_s[ACC_W]}}, sum2_s};
    clamp2_s  = sabr_sat(wide2_s, ACC_W);
    acc_nxt_s = ACC_W'(clamp2_s);
    sat2_s    = (clamp2_s != wide2_s);
`else
    acc_nxt_s = ACC_W'(sum2_s);
    sat2_s    = 1'b0;
`endif
  end

  // FSM state plus registered status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      out_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else if (ce) begin
      state_r   <= state_s;
      out_vld_r <= (state_s == ST_DONE);
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Step counter, accumulator and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      acc_r <= '0;
      sat_r <= 1'b0;
      ovr_r <= 1'b0;
    end else if (ce) begin
      if ((state_r == ST_IDLE) && start) begin
        cnt_r <= n_steps;
        acc_r <= init_val;
        sat_r <= 1'b0;
        ovr_r <= 1'b0;
      end else begin
        if (accept_s) begin
          cnt_r <= cnt_r - STEP_W'(1);
        end
        // Stage 1 only produces data in ACCUM, so this never races the IDLE load.
        if (s1_vld_s) begin
          acc_r <= acc_nxt_s;
          if (s1_sat_s || sat2_s) begin
            sat_r <= 1'b1;
          end
        end
        if (prod_vld && ((state_r == ST_FLUSH) || (state_r == ST_DONE))) begin
          ovr_r <= 1'b1;
        end
      end
    end
  end

  assign acc_out  = acc_r;
  assign out_vld  = out_vld_r;
  assign busy     = busy_r;
  assign sat_flag = sat_r;
  assign ovr_flag = ovr_r;

endmodule

// File: tb/tb_sabr_step_accum.sv
// Directed, scoreboard-checked bench for sabr_step_accum (default widths).
module tb_sabr_step_accum;

  localparam int PROD_W = 90;
  localparam int SHIFT  = 48;
  localparam int ACC_W  = 64;
  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ce;
  logic              start;
  logic [STEP_W-1:0] n_steps;
  logic [ACC_W-1:0]  init_val;
  logic              prod_vld;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_out;
  logic              out_vld;
  logic              out_rdy;
  logic              busy;
  logic              sat_flag;
  logic              ovr_flag;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic             ovr;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [PROD_W-1:0] pv[4];

  sabr_step_accum dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .n_steps  (n_steps),
    .init_val (init_val),
    .prod_vld (prod_vld),
    .prod     (prod),
    .acc_out  (acc_out),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .busy     (busy),
    .sat_flag (sat_flag),
    .ovr_flag (ovr_flag)
  );

  always #5 clk = ~clk;

  // k * 2^SHIFT as a PROD_W-bit two's-complement product.
  function automatic logic [PROD_W-1:0] pq(input longint k);
    logic signed [PROD_W-1:0] t;
    t = {{(PROD_W-64){k[63]}}, k};
    return t <<< SHIFT;
  endfunction

  task automatic chk(input string nm, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, $signed(act), act, $signed(exp_v), exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int n, input logic [ACC_W-1:0] init);
    start    = 1'b1;
    n_steps  = STEP_W'(n);
    init_val = init;
    step();
    start    = 1'b0;
  endtask

  task automatic feed(input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        ce       = 1'b0;
        prod_vld = 1'b1;
        prod     = ~pv[i];
        step();
        ce       = 1'b1;
        prod_vld = 1'b0;
        step();
      end
      prod_vld = 1'b1;
      prod     = pv[i];
      step();
    end
    prod_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ce && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got acc %0d with no expectation queued", $signed(acc_out));
      end else begin
        mon_e = sb.pop_front();
        chk("sb_acc", acc_out, mon_e.acc);
        chk("sb_sat", ACC_W'(sat_flag), ACC_W'(mon_e.sat));
        chk("sb_ovr", ACC_W'(ovr_flag), ACC_W'(mon_e.ovr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; start = 1'b0; n_steps = '0; init_val = '0;
    prod_vld = 1'b0; prod = '0; out_rdy = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_out_vld", ACC_W'(out_vld), 64'd0);
    chk("rst_busy", ACC_W'(busy), 64'd0);
    chk("rst_acc", acc_out, 64'd0);
    chk("rst_sat", ACC_W'(sat_flag), 64'd0);
    chk("rst_ovr", ACC_W'(ovr_flag), 64'd0);

    // Rounding case 1 with the two-cycle latency check.
    sb.push_back('{acc: 64'd13, sat: 1'b0, ovr: 1'b0});
    issue_start(1, 64'd10);
    prod_vld = 1'b1; prod = pq(3);
    step();
    prod_vld = 1'b0;
    chk("lat_t1_out_vld", ACC_W'(out_vld), 64'd0);
    step();
    chk("lat_t2_out_vld", ACC_W'(out_vld), 64'd1);
    drain();

    // Rounding case 2: +half, -half (rounds up to 0), just below -half.
    pv[0] = pq(1) >> 1;
    sb.push_back('{acc: 64'd11, sat: 1'b0, ovr: 1'b0});
    issue_start(1, 64'd10); feed(1, 1'b0); drain();
    pv[0] = pq(-1) >>> 1;
    pv[0] = {1'b1, pv[0][PROD_W-2:0]};
    sb.push_back('{acc: 64'd10, sat: 1'b0, ovr: 1'b0});
    issue_start(1, 64'd10); feed(1, 1'b0); drain();
    pv[0] = pv[0] - 90'd1;
    sb.push_back('{acc: 64'd9, sat: 1'b0, ovr: 1'b0});
    issue_start(1, 64'd10); feed(1, 1'b0); drain();

    // Four gapped products with ce toggled (ce-low products must be ignored).
    pv[0] = pq(1); pv[1] = pq(2); pv[2] = pq(-5); pv[3] = pq(7);
    sb.push_back('{acc: 64'd5, sat: 1'b0, ovr: 1'b0});
    issue_start(4, 64'd0); feed(4, 1'b1); drain();

    // Overflow of the accumulator near the positive limit.
    pv[0] = pq(5);
`ifdef SABR_STEP_ACC_SAT_EN
    sb.push_back('{acc: 64'h7FFF_FFFF_FFFF_FFFF, sat: 1'b1, ovr: 1'b0});
`else
    sb.push_back('{acc: 64'h8000_0000_0000_0003, sat: 1'b0, ovr: 1'b0});
`endif
    issue_start(1, 64'h7FFF_FFFF_FFFF_FFFE); feed(1, 1'b0); drain();

    // Backpressure in DONE with an overrun pulse, then a start during the handshake.
    out_rdy = 1'b0;
    pv[0] = pq(1);
    sb.push_back('{acc: 64'd1, sat: 1'b0, ovr: 1'b1});
    issue_start(1, 64'd0); feed(1, 1'b0);
    step();
    chk("bp_enter_done", ACC_W'(out_vld), 64'd1);
    for (int i = 0; i < 5; i++) begin
      prod_vld = (i == 1);
      step();
      chk("bp_out_vld_held", ACC_W'(out_vld), 64'd1);
      chk("bp_acc_stable", acc_out, 64'd1);
    end
    prod_vld = 1'b0;
    chk("bp_ovr_flag", ACC_W'(ovr_flag), 64'd1);
    chk("bp_busy", ACC_W'(busy), 64'd1);
    out_rdy = 1'b1; start = 1'b1; n_steps = '0; init_val = 64'd99;
    step();
    start = 1'b0;
    chk("bp_idle_busy", ACC_W'(busy), 64'd0);
    chk("bp_idle_out_vld", ACC_W'(out_vld), 64'd0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_handshake: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    sb.push_back('{acc: 64'd3, sat: 1'b0, ovr: 1'b0});
    issue_start(0, 64'd3);
    chk("new_start_ovr_clr", ACC_W'(ovr_flag), 64'd0);
    drain();

    // Reset after two of four back-to-back products; then a zero-step path.
    pv[0] = pq(4); pv[1] = pq(6);
    issue_start(4, 64'd100); feed(2, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", ACC_W'(busy), 64'd0);
    chk("mid_rst_out_vld", ACC_W'(out_vld), 64'd0);
    chk("mid_rst_sat", ACC_W'(sat_flag), 64'd0);
    chk("mid_rst_ovr", ACC_W'(ovr_flag), 64'd0);
    chk("mid_rst_acc", acc_out, 64'd0);
    sb.push_back('{acc: 64'd7, sat: 1'b0, ovr: 1'b0});
    start = 1'b1; n_steps = '0; init_val = 64'd7; prod_vld = 1'b1; prod = pq(2);
    step();
    start = 1'b0; prod_vld = 1'b0;
    drain();

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
